nn_layer_sequencer: RTL



---
 rtl/nn_pkg.sv | 41 ++++
 rtl/nn_argmax_tracker.sv | 38 +++
 rtl/nn_layer_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the two-layer MNIST inference sequencer.
package nn_pkg;

  localparam int DEF_N_IN   = 784;
  localparam int DEF_N_HID  = 8;
  localparam int DEF_N_OUT  = 10;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_ACC_W  = 32;

  localparam int NUM_BIAS      = 18;
  localparam int OUT_BIAS_BASE = 8;
  localparam int FEAT_AW       = 10;
  localparam int W_AW          = 13;
  localparam int HID_AW        = 3;
  localparam int NEUR_W        = 4;
  localparam int CLASS_W       = 4;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_SAT       = 2;
  localparam int STAT_CLASS_LSB = 4;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4,
    ST_DONE   = 3'd5
  } nn_state_e;

  // Cycles from the start-sampling edge through the edge that raises done.
  function automatic int nn_run_cycles(input int n_in, input int n_hid,
                                       input int n_out, input int rd_lat);
    return n_hid * (n_in + rd_lat + 3) + n_out * (n_hid + rd_lat + 3) + 2;
  endfunction

endpackage

// File: rtl/nn_argmax_tracker.sv
// Running argmax over output-layer scores; strict greater-than so ties keep
// the earlier (lower) index, and the first valid score always seeds the max.
module nn_argmax_tracker
  import nn_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int IDX_W = CLASS_W
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    i_clear,
  input  logic                    i_valid,
  input  logic signed [ACC_W-1:0] i_score,
  input  logic [IDX_W-1:0]        i_index,
  output logic [IDX_W-1:0]        o_best_idx,
  output logic signed [ACC_W-1:0] o_best_score
);

  logic                    r_have;
  logic [IDX_W-1:0]        r_best_idx;
  logic signed [ACC_W-1:0] r_best_score;

  always_ff @(posedge aclk) begin
    if (!aresetn || i_clear) begin
      r_have       <= 1'b0;
      r_best_idx   <= '0;
      r_best_score <= '0;
    end else if (i_valid && (!r_have || (i_score > r_best_score))) begin
      r_have       <= 1'b1;
      r_best_idx   <= i_index;
      r_best_score <= i_score;
    end
  end

  assign o_best_idx   = r_best_idx;
  assign o_best_score = r_best_score;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks both fully connected layers neuron by neuron: streams operand addresses,
// drives the external MAC, adds bias with saturation, ReLU/writeback or argmax.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_HID  = DEF_N_HID,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [31:0]               i_control,
  input  logic [NUM_BIAS*ACC_W-1:0] i_bias_flat,
  output logic [31:0]               o_status,
  output logic [FEAT_AW-1:0]        o_feat_addr,
  output logic                      o_feat_sel,
  output logic [W_AW-1:0]           o_w_addr,
  output logic                      o_acc_clr,
  output logic                      o_acc_en,
  input  logic signed [ACC_W-1:0]   i_acc_result,
  output logic                      o_hid_we,
  output logic [HID_AW-1:0]         o_hid_waddr,
  output logic [ACC_W-1:0]          o_hid_wdata
);

  nn_state_e r_state;
  nn_state_e w_state_next;

  logic                    r_ctrl0;
  logic                    r_layer;
  logic [NEUR_W-1:0]       r_neuron;
  logic [FEAT_AW-1:0]      r_idx;
  logic [2:0]              r_drain;
  logic [RD_LAT-1:0]       r_vld_sr;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_sat;
  logic [CLASS_W-1:0]      r_class;

  logic                    w_start_pulse;
  logic                    w_abort;
  logic                    w_abort_run;
  logic                    w_stream_vld;
  logic [FEAT_AW-1:0]      w_k_last;
  logic                    w_last_neuron;
  logic                    w_drain_last;
  logic [4:0]              w_bias_idx;
  logic signed [ACC_W-1:0] w_bias;
  logic [ACC_W:0]          w_sum_wide;
  logic                    w_ovf;
  logic signed [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0]        w_relu;
  logic [W_AW-1:0]         w_waddr_l1;
  logic [W_AW-1:0]         w_waddr_l2;
  logic                    w_finish;
  logic [CLASS_W-1:0]      w_best_idx;
  logic signed [ACC_W-1:0] w_best_score;
  logic                    w_unused;

  assign w_start_pulse = i_control[CTRL_START] & ~r_ctrl0;
  assign w_abort       = i_control[CTRL_ABORT];
  assign w_abort_run   = w_abort & (r_state != ST_IDLE);
  assign w_stream_vld  = (r_state == ST_STREAM);
  assign w_finish      = (r_state == ST_FINISH) & ~w_abort;

  assign w_k_last      = r_layer ? FEAT_AW'(N_HID - 1) : FEAT_AW'(N_IN - 1);
  assign w_last_neuron = r_layer ? (r_neuron == NEUR_W'(N_OUT - 1))
                                 : (r_neuron == NEUR_W'(N_HID - 1));
  assign w_drain_last  = (r_drain == 3'(RD_LAT));

  assign w_waddr_l1 = W_AW'(int'(r_neuron) * N_IN + int'(r_idx));
  assign w_waddr_l2 = W_AW'(N_HID * N_IN + int'(r_neuron) * N_HID + int'(r_idx));

  // Hidden neurons use bias_0.., output neurons use bias_8..
  assign w_bias_idx = r_layer ? (5'(OUT_BIAS_BASE) + 5'(r_neuron)) : 5'(r_neuron);
  assign w_bias     = i_bias_flat[w_bias_idx*ACC_W +: ACC_W];

  // One guard bit catches signed overflow; clamp to the ACC_W range.
  assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_bias[ACC_W-1], w_bias};
  assign w_ovf      = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
  assign w_sum      = !w_ovf ? w_sum_wide[ACC_W-1:0]
                    : (w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}});
  assign w_relu     = w_sum[ACC_W-1] ? '0 : w_sum;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_abort_run) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_start_pulse && !w_abort) w_state_next = ST_CLR;
        ST_CLR:    w_state_next = ST_STREAM;
        ST_STREAM: if (r_idx == w_k_last) w_state_next = ST_DRAIN;
        ST_DRAIN:  if (w_drain_last) w_state_next = ST_FINISH;
        ST_FINISH: w_state_next = (r_layer && w_last_neuron) ? ST_DONE : ST_CLR;
        ST_DONE:   w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_acc_clr   = 1'b0;
    o_feat_addr = '0;
    o_feat_sel  = 1'b0;
    o_w_addr    = '0;
    o_hid_we    = 1'b0;
    o_hid_waddr = '0;
    o_hid_wdata = '0;
    if (!w_abort) begin
      case (r_state)
        ST_CLR: o_acc_clr = 1'b1;
        ST_STREAM: begin
          o_feat_addr = r_idx;
          o_feat_sel  = r_layer;
          o_w_addr    = r_layer ? w_waddr_l2 : w_waddr_l1;
        end
        ST_FINISH: begin
          if (!r_layer) begin
            o_hid_we    = 1'b1;
            o_hid_waddr = r_neuron[HID_AW-1:0];
            o_hid_wdata = w_relu;
          end
        end
        default: ;
      endcase
    end
  end

  // acc_en tracks the memory read latency of each streamed address pair.
  always_ff @(posedge aclk) begin
    if (!aresetn || w_abort_run) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr <= RD_LAT'({r_vld_sr, w_stream_vld});
    end
  end

  assign o_acc_en = r_vld_sr[RD_LAT-1] & ~w_abort;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ctrl0  <= 1'b0;
      r_layer  <= 1'b0;
      r_neuron <= '0;
      r_idx    <= '0;
      r_drain  <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
      r_class  <= '0;
    end else begin
      r_ctrl0 <= i_control[CTRL_START];
      if (w_abort_run) begin
        r_busy   <= 1'b0;
        r_layer  <= 1'b0;
        r_neuron <= '0;
        r_idx    <= '0;
        r_drain  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_pulse && !w_abort) begin
              r_busy   <= 1'b1;
              r_done   <= 1'b0;
              r_sat    <= 1'b0;
              r_layer  <= 1'b0;
              r_neuron <= '0;
            end
          end
          ST_CLR: begin
            r_idx   <= '0;
            r_drain <= '0;
          end
          ST_STREAM: r_idx <= r_idx + 1'b1;
          ST_DRAIN: begin
            r_drain <= r_drain + 1'b1;
            if (w_drain_last) r_acc <= i_acc_result;
          end
          ST_FINISH: begin
            if (w_ovf) r_sat <= 1'b1;
            if (w_last_neuron) begin
              r_layer  <= 1'b1;
              r_neuron <= '0;
            end else begin
              r_neuron <= r_neuron + 1'b1;
            end
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_class <= w_best_idx;
          end
          default: ;
        endcase
      end
    end
  end

  nn_argmax_tracker #(
    .ACC_W (ACC_W),
    .IDX_W (CLASS_W)
  ) u_argmax (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .i_clear      (w_start_pulse & ~w_abort & (r_state == ST_IDLE)),
    .i_valid      (w_finish & r_layer),
    .i_score      (w_sum),
    .i_index      (r_neuron),
    .o_best_idx   (w_best_idx),
    .o_best_score (w_best_score)
  );

  always_comb begin
    o_status                                 = '0;
    o_status[STAT_BUSY]                      = r_busy;
    o_status[STAT_DONE]                      = r_done;
    o_status[STAT_SAT]                       = r_sat;
    o_status[STAT_CLASS_LSB +: CLASS_W]      = r_class;
  end

  assign w_unused = ^{i_control[31:CTRL_ABORT+1], w_best_score};

endmodule
